if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Fetch-stage control block that sits directly upstream of the instruction fetch buffer. It owns the fetch PC and issues one I-cache lookup per cycle. It extracts the 32-bit instruction from the returned 64-bit line and writes instruction, PC, predicted next PC and prediction bit into the fetch buffer whenever that buffer is not full. It also handles I-cache miss stalls, branch-predictor redirects, ROB flush recovery and halt detection, and keeps two performance counters.

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset
HALT_INSN, 32'h0000_0555, encoding that stops fetch after it is enqueued
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
icache_addr_o  out  64  lookup address; equals the current fetch PC with bits [2:0] cleared
icache_req_o  out  1  lookup valid
icache_hit_i  in  1  same-cycle hit for icache_addr_o
icache_data_i  in  64  line data, valid when hit
bp_pc_o  out  64  PC presented to the branch predictor; equals the fetch PC
bp_taken_i  in  1  predicted taken for bp_pc_o (combinational)
bp_target_i  in  64  predicted target for bp_pc_o
flush_en_i  in  1  ROB mispredict/exception flush
flush_target_pc_i  in  64  restart PC on flush
ifb_full_i  in  1  fetch buffer full
ifb_en_o  out  1  write strobe into the fetch buffer
if_insn_o  out  32  fetched instruction
if_PC_o  out  64  PC of if_insn_o
if_target_PC_o  out  64  predicted next PC
if_pred_bit_o  out  1  predicted-taken bit
halted_o  out  1  fetch stopped on HALT_INSN
fetch_cnt_o  out  CNT_W  instructions enqueued
miss_cnt_o  out  CNT_W  cycles spent in MISS

Behaviour:
- States are FETCH, MISS and HALTED. Reset puts the block in FETCH with PC=RESET_PC and both counters at 0.
- While rst is high, all outputs are 0, except icache_addr_o and bp_pc_o, which show RESET_PC.
- Instruction word select: if_insn_o is icache_data_i[63:32] when PC[2]=1, otherwise icache_data_i[31:0].
- icache_req_o = 1 in FETCH and MISS, and 0 in HALTED.
- next_pc = bp_taken_i ? bp_target_i : PC+4, using 64-bit wrapping add.
- if_target_PC_o = next_pc and if_pred_bit_o = bp_taken_i.
- if_PC_o = PC at all times.
- ifb_en_o = (state FETCH or MISS) & icache_hit_i & ~ifb_full_i & ~flush_en_i. It is combinational, so there is zero-cycle latency from hit to the buffer write.
- Transitions, evaluated at each clk edge; flush has highest priority:
  - flush_en_i from any state: PC <= flush_target_pc_i, state <= FETCH. Any same-cycle hit is discarded and no write occurs.
  - FETCH or MISS with ifb_en_o=1 and the instruction equal to HALT_INSN: the HALT is enqueued, PC <= PC+4, state <= HALTED.
  - FETCH or MISS with ifb_en_o=1 otherwise: PC <= next_pc, state <= FETCH.
  - FETCH or MISS with a hit but ifb_full_i=1: PC holds and state <= FETCH. The same lookup is replayed next cycle.
  - FETCH or MISS with no hit: PC holds, state <= MISS.
  - HALTED without flush: everything holds.
- halted_o = (state == HALTED).
- fetch_cnt_o increments by 1 on each ifb_en_o.
- miss_cnt_o increments by 1 on each cycle the block is in MISS without flush.
- Both counters saturate at all-ones. They are cleared only by rst, not by flush.
- A full buffer with a simultaneous hit produces no write and no PC advance; nothing is lost.
- A redirect is applied only when the instruction is actually enqueued. The predictor output is therefore re-sampled on every replay.
- A reset mid-miss or while halted returns the block to FETCH at RESET_PC within one edge.

Test Plan:
- Reset, then constant hit with PCs 0,4,8 and no prediction -> ifb_en_o=1 each cycle; if_PC_o 0,4,8; if_target_PC_o 4,8,12; fetch_cnt_o=3.
- At PC=0x10, hit with bp_taken_i=1 and bp_target_i=0x100 -> enqueue with if_pred_bit_o=1 and if_target_PC_o=0x100; next cycle if_PC_o=0x100.
- At PC=0x20, icache_hit_i=0 for 3 cycles and then 1 -> state MISS; ifb_en_o=0 for 3 cycles; miss_cnt_o=3; the 0x20 instruction is enqueued on the 4th cycle.
- ifb_full_i=1 for 2 cycles with a hit at PC=0x8 -> no write and PC stays 0x8; after full deasserts, a single write with if_PC_o=0x8 follows.
- During MISS, flush_en_i=1 with flush_target_pc_i=0x400 together with a hit -> no write; next cycle state FETCH and PC=0x400.
- Data word 0x00000555 at PC=0xC (upper half) -> HALT is enqueued; halted_o=1; icache_req_o=0; later flush to 0x0 resumes fetch.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, looks up the I-cache each cycle and
// writes the selected instruction plus its prediction into the fetch buffer.
module if_fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_INSN = 32'h0000_0555,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [63:0]      icache_addr_o,
    output logic             icache_req_o,
    input  logic             icache_hit_i,
    input  logic [63:0]      icache_data_i,
    output logic [63:0]      bp_pc_o,
    input  logic             bp_taken_i,
    input  logic [63:0]      bp_target_i,
    input  logic             flush_en_i,
    input  logic [63:0]      flush_target_pc_i,
    input  logic             ifb_full_i,
    output logic             ifb_en_o,
    output logic [31:0]      if_insn_o,
    output logic [63:0]      if_PC_o,
    output logic [63:0]      if_target_PC_o,
    output logic             if_pred_bit_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    // state   | meaning
    // FETCH   | issuing lookups, last lookup hit (or replaying after full buffer)
    // MISS    | last lookup missed, retrying the same PC
    // HALTED  | HALT_INSN enqueued, fetch stopped until flush or reset
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_MISS   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state;
    logic [63:0]      pc;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    logic             active;
    logic             enq;
    logic [31:0]      insn;
    logic [63:0]      pc_inc;
    logic [63:0]      next_pc;

    always_comb begin
        active  = (state == S_FETCH) || (state == S_MISS);
        insn    = pc[2] ? icache_data_i[63:32] : icache_data_i[31:0];
        pc_inc  = pc + 64'd4;
        next_pc = bp_taken_i ? bp_target_i : pc_inc;
        enq     = active && icache_hit_i && !ifb_full_i && !flush_en_i;
    end

    // Everything reads as idle while reset is held; only the lookup address
    // already points at the restart PC.
    always_comb begin
        icache_addr_o  = rst ? {RESET_PC[63:3], 3'b000} : {pc[63:3], 3'b000};
        bp_pc_o        = rst ? RESET_PC : pc;
        icache_req_o   = !rst && active;
        ifb_en_o       = !rst && enq;
        if_insn_o      = rst ? 32'd0 : insn;
        if_PC_o        = rst ? 64'd0 : pc;
        if_target_PC_o = rst ? 64'd0 : next_pc;
        if_pred_bit_o  = !rst && bp_taken_i;
        halted_o       = !rst && (state == S_HALTED);
        fetch_cnt_o    = rst ? '0 : fetch_cnt;
        miss_cnt_o     = rst ? '0 : miss_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            fetch_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            if (enq && (fetch_cnt != '1))
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            if ((state == S_MISS) && !flush_en_i && (miss_cnt != '1))
                miss_cnt <= miss_cnt + CNT_W'(1);

            if (flush_en_i) begin
                pc    <= flush_target_pc_i;
                state <= S_FETCH;
            end else begin
                case (state)
                    S_FETCH, S_MISS: begin
                        if (enq && (insn == HALT_INSN)) begin
                            pc    <= pc_inc;
                            state <= S_HALTED;
                        end else if (enq) begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end else if (icache_hit_i) begin
                            // buffer full: replay the same lookup
                            state <= S_FETCH;
                        end else begin
                            state <= S_MISS;
                        end
                    end
                    S_HALTED: state <= S_HALTED;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end

endmodule
